// File: rtl/vpu_axi_pkg.sv
// Shared AXI constants, response codes and DMA state encoding for the VPU load path.
package vpu_axi_pkg;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } dma_state_e;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/vec_load_dma_if.sv
// AXI4 read-address and read-data channels between the vector load DMA and its slave.
interface vec_load_dma_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m_AXI_ARADDR;
    logic [3:0]            m_AXI_ARID;
    logic [7:0]            m_AXI_ARLEN;
    logic [2:0]            m_AXI_ARSIZE;
    logic [1:0]            m_AXI_ARBURST;
    logic                  m_AXI_ARVALID;
    logic                  m_AXI_ARREADY;

    logic [DATA_WIDTH-1:0] m_AXI_RDATA;
    logic [1:0]            m_AXI_RRESP;
    logic [3:0]            m_AXI_RID;
    logic                  m_AXI_RLAST;
    logic                  m_AXI_RVALID;
    logic                  m_AXI_RREADY;

    modport master (
        output m_AXI_ARADDR, m_AXI_ARID, m_AXI_ARLEN, m_AXI_ARSIZE, m_AXI_ARBURST,
        output m_AXI_ARVALID,
        input  m_AXI_ARREADY,
        input  m_AXI_RDATA, m_AXI_RRESP, m_AXI_RID, m_AXI_RLAST, m_AXI_RVALID,
        output m_AXI_RREADY
    );

    modport slave (
        input  m_AXI_ARADDR, m_AXI_ARID, m_AXI_ARLEN, m_AXI_ARSIZE, m_AXI_ARBURST,
        input  m_AXI_ARVALID,
        output m_AXI_ARREADY,
        output m_AXI_RDATA, m_AXI_RRESP, m_AXI_RID, m_AXI_RLAST, m_AXI_RVALID,
        input  m_AXI_RREADY
    );

endinterface

// File: rtl/vpu_sync_fifo.sv
// Synchronous FIFO; the head entry is read straight from storage registers, so a
// word pushed on one edge is visible at the output during the following cycle.
module vpu_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vec_load_dma.sv
// AXI4 read master: fetches a contiguous run of 32-bit words with single-beat reads,
// one outstanding at a time, and streams them out through a small FIFO.
module vec_load_dma
    import vpu_axi_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         LEN_WIDTH  = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] AXI_ID     = 4'h0
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,

    vec_load_dma_if.master        axi,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    dma_state_e            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  inflight;
    logic                  done_q;
    logic                  err_q;

    logic                  cmd_fire;
    logic                  ar_fire;
    logic                  r_fire;
    logic                  credit_ok;
    logic                  last_beat;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      used;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH:0]   fifo_rdata;

    // A slot is reserved for every read in flight, so an accepted R beat always fits.
    assign used      = fifo_count + CNT_W'(inflight);
    assign credit_ok = (used < CNT_W'(FIFO_DEPTH));

    assign cmd_ready = (state == ST_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign last_beat = (remaining == LEN_WIDTH'(1));

    // ARVALID decodes registered state and FIFO occupancy only; occupancy cannot
    // rise while in ADDR, so once raised it holds until ARREADY.
    assign axi.m_AXI_ARADDR  = addr;
    assign axi.m_AXI_ARID    = AXI_ID;
    assign axi.m_AXI_ARLEN   = 8'h00;
    assign axi.m_AXI_ARSIZE  = AXI_SIZE_4B;
    assign axi.m_AXI_ARBURST = AXI_BURST_INCR;
    assign axi.m_AXI_ARVALID = (state == ST_ADDR) && credit_ok;
    assign axi.m_AXI_RREADY  = (state == ST_DATA);

    assign ar_fire = axi.m_AXI_ARVALID && axi.m_AXI_ARREADY;
    assign r_fire  = axi.m_AXI_RVALID && axi.m_AXI_RREADY;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        err_q <= 1'b0;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr      <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                            remaining <= cmd_len;
                            state     <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (ar_fire) begin
                        inflight <= 1'b1;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_fire) begin
                        inflight  <= 1'b0;
                        addr      <= addr + ADDR_WIDTH'(4);
                        remaining <= remaining - 1'b1;
                        if (resp_is_error(axi.m_AXI_RRESP)) begin
                            err_q <= 1'b1;
                        end
                        if (last_beat) begin
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            state  <= ST_ADDR;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    vpu_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (r_fire),
        .wdata ({last_beat, axi.m_AXI_RDATA}),
        .pop   (out_valid && out_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rdata[DATA_WIDTH-1:0];
    assign out_last  = fifo_rdata[DATA_WIDTH];

    // RID, RLAST and the byte-offset bits of the command address carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, axi.m_AXI_RID, axi.m_AXI_RLAST, cmd_addr[1:0], fifo_full};

endmodule

// File: doc/vec_load_dma.md
# vec_load_dma

AXI4 read master that fetches a contiguous vector of 32-bit words from the SRAM slave and streams them to the softmax datapath. A command (base address, word count) is issued as a sequence of single-beat reads, with one outstanding transaction at a time. Returned words are buffered in a small FIFO and presented on a valid/ready stream, with the final element marked. The block sits directly upstream of the SRAM AXI slave on the read channels and feeds the VPU compute stage.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: AXI and stream data width; only 32 is supported.
- `LEN_WIDTH`, 16: width of the command word count.
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of two and ≥ 2.
- `AXI_ID`, 4'h0: constant ARID value.

Ports:
- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: **synchronous, active-high**.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_addr` in ADDR_WIDTH: byte base address; bits [1:0] are ignored and forced to 0.
- `cmd_len` in LEN_WIDTH: number of words to fetch; 0 is legal.
- `busy` out 1: a command is in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: sticky error flag; cleared on acceptance of the next command.
- `m_AXI_ARADDR` out ADDR_WIDTH, `m_AXI_ARID` out 4, `m_AXI_ARLEN` out 8, `m_AXI_ARSIZE` out 3, `m_AXI_ARBURST` out 2: read-address channel fields.
- `m_AXI_ARVALID` out 1, `m_AXI_ARREADY` in 1: read-address handshake.
- `m_AXI_RDATA` in DATA_WIDTH, `m_AXI_RRESP` in 2, `m_AXI_RID` in 4, `m_AXI_RLAST` in 1: read-data channel fields.
- `m_AXI_RVALID` in 1, `m_AXI_RREADY` out 1: read-data handshake.
- `out_valid` out 1, `out_ready` in 1: output stream handshake.
- `out_data` out DATA_WIDTH: stream data.
- `out_last` out 1: marks the final word of a command.

## Operation
- Fixed AR fields: ARLEN=0, ARSIZE=3'b010, ARBURST=2'b01 (INCR), ARID=AXI_ID.
- FSM states are IDLE, ADDR and DATA.
- **IDLE**
  - `cmd_ready`=1.
  - On cmd handshake with len=0: pulse `done` next cycle, stay in IDLE.
  - On cmd handshake with len>0: latch addr and remaining=len, clear `err`, go to ADDR.
- **ADDR**
  - ARVALID=1 only when FIFO count + in-flight < FIFO_DEPTH (credit check).
  - Once asserted, ARVALID and ARADDR hold stable until ARREADY.
  - On the AR handshake, go to DATA.
- **DATA**
  - RREADY=1; a FIFO slot is always reserved by the credit check.
  - On an R beat: push {RDATA, last = (remaining==1)}, then addr += 4 and remaining -= 1.
  - If remaining was 1: pulse `done` next cycle, go to IDLE. Otherwise go to ADDR.
- **Response check**
  - RRESP[1]=1 (SLVERR/DECERR) sets `err`; the data is still pushed and the command continues.
  - RRESP 2'b00 and 2'b01 are both accepted as success.
  - RID and RLAST are not checked.
- **Address arithmetic:** addr is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH, with no error.
- **FIFO behaviour**
  - The FIFO is not flushed between commands; a new command may start while the previous words drain.
  - Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- **Stream rule:** `out_data` and `out_last` hold stable while `out_valid` && !`out_ready`.

## Timing
- **Reset values:** state=IDLE, FIFO empty, cmd_ready=1, busy=0, done=0, err=0, ARVALID=0, RREADY=0, out_valid=0, ARADDR=0.
- **Reset mid-operation:** returns everything to the reset values and discards FIFO contents. The AXI slave is reset by the same reset.
- **Command to AR:** cmd handshake at cycle N; ARVALID is registered and high at N+1 (given credit).
- **R to stream:** R beat captured at cycle M; out_valid is high at M+1. There is no combinational path from RDATA to out_data.
- **Next AR:** asserted the cycle after the R handshake, unless credit is blocked.
- **Done:** `done` is high exactly the cycle after the final R beat; busy=0 in that same cycle.
- **Back-pressure:** with out_ready=0, at most FIFO_DEPTH reads are completed, then ARVALID stays 0 until a pop.

## Structure
- Shared package `vpu_axi_pkg` holds:
  - AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01;
  - RRESP codes;
  - the FSM state enum.
- Sub-module `vpu_sync_fifo` (parameters WIDTH, DEPTH) provides:
  - push, pop, full, empty and count outputs;
  - registered read data.
- The top level holds the FSM, address and remaining counters, the in-flight flag and the credit check.

## Test plan
- **Basic fetch:** cmd addr=0x8000_0000, len=3 with out_ready=1.
  - ARADDR sequence is 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - Three words are streamed, out_last on the third.
  - done pulses once.
- **Zero length:** cmd len=0 → no ARVALID, done pulses at N+1, out_valid stays 0.
- **Back-pressure:** len=8, FIFO_DEPTH=4, out_ready=0.
  - Exactly 4 AR handshakes, then ARVALID=0.
  - Releasing out_ready yields all 8 words in order.
- **Error response:** RRESP=2'b10 on beat 2 of 4 → err=1 after that beat; all 4 words are still delivered; err clears on the next cmd.
- **Address wrap:** addr=0xFFFF_FFFC, len=2 → ARADDR 0xFFFF_FFFC, then 0x0000_0000.
- **Reset mid-operation:** assert reset during DATA with 2 words queued → next cycle all outputs are at their reset values and out_valid=0; a new command then runs cleanly.
